nvdla_csb_responder: RTL and testbench

- CSB target model: the responder end of the NVDLA configuration-space bus that the HWPE control engine drives as initiator.
- Implements a small word-addressed register file with configurable read latency, non-posted write completion and a delayed level interrupt.
- Lets the HWPE wrapper, control engine and CSB streamer run in simulation and FPGA bring-up without the full NVDLA core.

---
 rtl/nvdla_package.sv | 30 +++
 rtl/nvdla_csb_intr_timer.sv | 51 +++++
 rtl/nvdla_csb_responder.sv | 146 ++++++++++++++
 tb/tb_nvdla_csb_responder.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvdla_package.sv
// Shared types for the NVDLA CSB responder model: FSM state, request bundle and
// response flags, plus a width helper that never returns zero.
package nvdla_package;

  typedef enum logic {
    RSP_IDLE = 1'b0,
    RSP_READ = 1'b1
  } state_csb_rsp_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic        write;
    logic        nposted;
  } ctrl_csb_req_t;

  typedef struct packed {
    logic        ready;
    logic        rdata_valid;
    logic [31:0] rdata;
    logic        wr_complete;
  } flags_csb_rsp_t;

  // Counter width for a value range of [0, v-1]; one bit minimum so v==1 still works.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/nvdla_csb_intr_timer.sv
// Interrupt countdown for the CSB responder: a kick (re)loads the delay, expiry
// latches a pending flag that stays up until write-1-to-clear.
module nvdla_csb_intr_timer
  import nvdla_package::*;
#(
  parameter int unsigned INTR_DELAY = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic kick_i,
  input  logic clear_i,
  output logic busy_o,
  output logic pending_o
);

  localparam int unsigned CNT_W = clog2_min1(INTR_DELAY + 1);

  logic [CNT_W-1:0] r_count;
  logic             r_busy;
  logic             r_pending;
  logic             w_expire;

  // A kick landing on the final count restarts the countdown instead of firing.
  assign w_expire = r_busy && (r_count == CNT_W'(1)) && !kick_i;

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (kick_i) begin
        r_count <= CNT_W'(INTR_DELAY);
        r_busy  <= 1'b1;
      end else if (r_busy) begin
        r_count <= r_count - 1'b1;
        if (r_count == CNT_W'(1)) r_busy <= 1'b0;
      end

      // Set beats a same-cycle clear so an interrupt is never lost.
      if (w_expire)     r_pending <= 1'b1;
      else if (clear_i) r_pending <= 1'b0;
    end
  end

  assign busy_o    = r_busy;
  assign pending_o = r_pending;

endmodule

// File: rtl/nvdla_csb_responder.sv
// CSB target model: word-addressed register file with fixed read latency,
// non-posted write completion and a delayed level interrupt via STATUS/KICK.
module nvdla_csb_responder
  import nvdla_package::*;
#(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned INTR_DELAY   = 8,
  parameter logic [15:0] ADDR_BASE    = 16'h0000,
  parameter logic [31:0] ERR_DATA     = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csb_valid_i,
  output logic        csb_ready_o,
  input  logic [15:0] csb_addr_i,
  input  logic [31:0] csb_wdat_i,
  input  logic        csb_write_i,
  input  logic        csb_nposted_i,
  output logic        csb_rdata_valid_o,
  output logic [31:0] csb_rdata_o,
  output logic        csb_wr_complete_o,
  output logic        intr_o,
  output logic        busy_o
);

  localparam int unsigned IDX_W      = clog2_min1(NUM_REGS);
  localparam int unsigned RCNT_W     = clog2_min1(READ_LATENCY);
  localparam logic [15:0] IDX_STATUS = 16'(NUM_REGS - 2);
  localparam logic [15:0] IDX_KICK   = 16'(NUM_REGS - 1);

  ctrl_csb_req_t     w_req;
  flags_csb_rsp_t    w_rsp;
  state_csb_rsp_t    r_state;
  logic [RCNT_W-1:0] r_rcnt;
  logic [31:0]       r_snapshot;
  logic [31:0]       r_rdata_hold;
  logic              r_wr_complete;
  logic [31:0]       r_regs [NUM_REGS];

  logic [15:0] w_idx;
  logic        w_in_range;
  logic        w_accept;
  logic        w_is_status;
  logic        w_is_kick;
  logic        w_store;
  logic        w_kick;
  logic        w_clear;
  logic        w_strobe;
  logic [31:0] w_rd_data;
  logic        w_busy;
  logic        w_pending;

  assign w_req = '{valid:   csb_valid_i,
                   addr:    csb_addr_i,
                   wdat:    csb_wdat_i,
                   write:   csb_write_i,
                   nposted: csb_nposted_i};

  // Offset wraps in 16 bits, so addresses below ADDR_BASE decode as out of range.
  assign w_idx       = w_req.addr - ADDR_BASE;
  assign w_in_range  = (w_idx < 16'(NUM_REGS));
  assign w_is_status = w_in_range && (w_idx == IDX_STATUS);
  assign w_is_kick   = w_in_range && (w_idx == IDX_KICK);
  assign w_accept    = w_req.valid && w_rsp.ready;

  assign w_store = w_accept && w_req.write && w_in_range && !w_is_status && !w_is_kick;
  assign w_kick  = w_accept && w_req.write && w_is_kick && w_req.wdat[0];
  assign w_clear = w_accept && w_req.write && w_is_status && w_req.wdat[0];

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_rd_data = ERR_DATA;
    if (w_in_range) begin
      if (w_is_status)    w_rd_data = {31'b0, w_pending};
      else if (w_is_kick) w_rd_data = {31'b0, w_busy};
      else                w_rd_data = r_regs[w_idx[IDX_W-1:0]];
    end
  end

  // NOTE: the register array is reset explicitly because software expects all-zero
  // contents after reset; this forces flops rather than a RAM macro.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_store) begin
      r_regs[w_idx[IDX_W-1:0]] <= w_req.wdat;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= RSP_IDLE;
      r_rcnt        <= '0;
      r_snapshot    <= '0;
      r_rdata_hold  <= '0;
      r_wr_complete <= 1'b0;
    end else begin
      r_wr_complete <= w_accept && w_req.write && w_req.nposted;
      case (r_state)
        RSP_IDLE: begin
          if (w_accept && !w_req.write) begin
            r_state    <= RSP_READ;
            r_rcnt     <= RCNT_W'(READ_LATENCY - 1);
            r_snapshot <= w_rd_data;
          end
        end
        RSP_READ: begin
          if (r_rcnt == '0) begin
            r_state      <= RSP_IDLE;
            r_rdata_hold <= r_snapshot;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end
        default: r_state <= RSP_IDLE;
      endcase
    end
  end

  // Read data shows the snapshot only during the strobe and the last delivered value otherwise.
  assign w_strobe          = (r_state == RSP_READ) && (r_rcnt == '0);
  assign w_rsp.ready       = (r_state == RSP_IDLE);
  assign w_rsp.rdata_valid = w_strobe;
  assign w_rsp.rdata       = w_strobe ? r_snapshot : r_rdata_hold;
  assign w_rsp.wr_complete = r_wr_complete;

  nvdla_csb_intr_timer #(
    .INTR_DELAY (INTR_DELAY)
  ) u_intr_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .kick_i    (w_kick),
    .clear_i   (w_clear),
    .busy_o    (w_busy),
    .pending_o (w_pending)
  );

  assign csb_ready_o       = w_rsp.ready;
  assign csb_rdata_valid_o = w_rsp.rdata_valid;
  assign csb_rdata_o       = w_rsp.rdata;
  assign csb_wr_complete_o = w_rsp.wr_complete;
  assign intr_o            = w_pending;
  assign busy_o            = w_busy;

endmodule

// File: tb/tb_nvdla_csb_responder.sv
// Self-checking bench for nvdla_csb_responder: directed scenarios plus random
// register traffic against an event-time reference model.
module tb_nvdla_csb_responder;

  localparam int unsigned NREG = 16;
  localparam int unsigned RL   = 2;
  localparam int unsigned ID   = 8;
  localparam logic [15:0] BASE = 16'h0000;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
  localparam logic [15:0] A_STATUS = BASE + 16'(NREG - 2);
  localparam logic [15:0] A_KICK   = BASE + 16'(NREG - 1);

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        csb_valid_i = 1'b0;
  logic        csb_ready_o;
  logic [15:0] csb_addr_i = '0;
  logic [31:0] csb_wdat_i = '0;
  logic        csb_write_i = 1'b0;
  logic        csb_nposted_i = 1'b0;
  logic        csb_rdata_valid_o;
  logic [31:0] csb_rdata_o;
  logic        csb_wr_complete_o;
  logic        intr_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  nvdla_csb_responder #(
    .NUM_REGS     (NREG),
    .READ_LATENCY (RL),
    .INTR_DELAY   (ID),
    .ADDR_BASE    (BASE),
    .ERR_DATA     (ERRD)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .csb_valid_i       (csb_valid_i),
    .csb_ready_o       (csb_ready_o),
    .csb_addr_i        (csb_addr_i),
    .csb_wdat_i        (csb_wdat_i),
    .csb_write_i       (csb_write_i),
    .csb_nposted_i     (csb_nposted_i),
    .csb_rdata_valid_o (csb_rdata_valid_o),
    .csb_rdata_o       (csb_rdata_o),
    .csb_wr_complete_o (csb_wr_complete_o),
    .intr_o            (intr_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model: storage array plus interrupt timing expressed as event cycles.
  logic [31:0] m_regs [NREG];
  bit          m_have_kick = 1'b0;
  int          m_kick_cyc  = 0;
  int          m_clr_eff   = 0;

  function automatic bit m_busy(input int c);
    return m_have_kick && (c > m_kick_cyc) && (c <= m_kick_cyc + int'(ID));
  endfunction

  function automatic bit m_pending(input int c);
    int fire;
    fire = m_kick_cyc + int'(ID) + 1;
    return m_have_kick && (c >= fire) && !((m_clr_eff > fire) && (c >= m_clr_eff));
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a, input int c);
    logic [15:0] idx;
    idx = a - BASE;
    if (int'(idx) >= int'(NREG)) return ERRD;
    if (int'(idx) == int'(NREG) - 2) return {31'b0, m_pending(c)};
    if (int'(idx) == int'(NREG) - 1) return {31'b0, m_busy(c)};
    return m_regs[int'(idx)];
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [31:0] d, input int c);
    logic [15:0] idx;
    idx = a - BASE;
    if (int'(idx) < int'(NREG)) begin
      if (int'(idx) == int'(NREG) - 2) begin
        if (d[0]) m_clr_eff = c + 1;
      end else if (int'(idx) == int'(NREG) - 1) begin
        if (d[0]) begin
          m_kick_cyc  = c;
          m_have_kick = 1'b1;
        end
      end else begin
        m_regs[int'(idx)] = d;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) m_regs[i] = '0;
    m_have_kick = 1'b0;
    m_kick_cyc  = 0;
    m_clr_eff   = 0;
  endtask

  task automatic set_idle();
    csb_valid_i   = 1'b0;
    csb_write_i   = 1'b0;
    csb_nposted_i = 1'b0;
    csb_addr_i    = '0;
    csb_wdat_i    = '0;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input bit np);
    int t;
    t = cyc;
    csb_valid_i   = 1'b1;
    csb_write_i   = 1'b1;
    csb_nposted_i = np;
    csb_addr_i    = a;
    csb_wdat_i    = d;
    @(negedge clk_i);
    checks++;
    if (csb_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready addr=%h got=%b exp=1", a, csb_ready_o);
    end
    tick();
    set_idle();
    model_write(a, d, t);
    @(negedge clk_i);
    checks++;
    if (csb_wr_complete_o !== 1'(np)) begin
      errors++;
      $display("FAIL wr_complete addr=%h got=%b exp=%b", a, csb_wr_complete_o, np);
    end
    tick();
  endtask

  task automatic do_read(input logic [15:0] a);
    int t;
    logic [31:0] exp;
    t   = cyc;
    exp = model_read(a, t);
    csb_valid_i   = 1'b1;
    csb_write_i   = 1'b0;
    csb_nposted_i = 1'b0;
    csb_addr_i    = a;
    csb_wdat_i    = $urandom;
    @(negedge clk_i);
    checks++;
    if (csb_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rd_accept addr=%h got=%b exp=1", a, csb_ready_o);
    end
    tick();
    set_idle();
    for (int k = 1; k <= int'(RL) + 1; k++) begin
      @(negedge clk_i);
      checks++;
      if (csb_ready_o !== 1'(k == int'(RL) + 1)) begin
        errors++;
        $display("FAIL rd_ready addr=%h T+%0d got=%b exp=%b", a, k, csb_ready_o, k == int'(RL) + 1);
      end
      checks++;
      if (csb_rdata_valid_o !== 1'(k == int'(RL))) begin
        errors++;
        $display("FAIL rd_valid addr=%h T+%0d got=%b exp=%b", a, k, csb_rdata_valid_o, k == int'(RL));
      end
      if (k >= int'(RL)) begin
        checks++;
        if (csb_rdata_o !== exp) begin
          errors++;
          $display("FAIL rd_data addr=%h T+%0d got=%h exp=%h", a, k, csb_rdata_o, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [37:0] got;
    rst_i = 1'b1;
    set_idle();
    model_reset();
    repeat (2) tick();
    got = {csb_ready_o, csb_rdata_valid_o, csb_rdata_o, csb_wr_complete_o, intr_o, busy_o};
    checks++;
    if (got !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold outputs got=%h exp=%h", got, {1'b1, 1'b0, 32'h0, 3'b000});
    end
    rst_i = 1'b0;
    tick();
    @(negedge clk_i);
    got = {csb_ready_o, csb_rdata_valid_o, csb_rdata_o, csb_wr_complete_o, intr_o, busy_o};
    checks++;
    if (got !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release outputs got=%h exp=%h", got, {1'b1, 1'b0, 32'h0, 3'b000});
    end
    tick();
  endtask

  task automatic test_read_basic();
    do_read(BASE + 16'd3);
  endtask

  task automatic test_write_read();
    do_write(BASE + 16'd5, 32'hCAFE_F00D, 1'b1);
    do_read(BASE + 16'd5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      csb_valid_i   = 1'b1;
      csb_write_i   = 1'b1;
      csb_nposted_i = 1'b0;
      csb_addr_i    = BASE + 16'(i);
      csb_wdat_i    = d;
      @(negedge clk_i);
      checks++;
      if (csb_ready_o !== 1'b1 || csb_wr_complete_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b_accept beat=%0d got ready=%b wc=%b exp ready=1 wc=0", i, csb_ready_o, csb_wr_complete_o);
      end
      model_write(BASE + 16'(i), d, cyc);
      tick();
    end
    set_idle();
    @(negedge clk_i);
    checks++;
    if (csb_wr_complete_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_complete got=%b exp=0", csb_wr_complete_o);
    end
    tick();
    for (int i = 0; i < 3; i++) do_read(BASE + 16'(i));
  endtask

  task automatic test_intr();
    int c;
    int rise;
    int t0;
    logic [15:0] a;
    logic [31:0] d;
    bit wr;
    rise = -1;
    t0   = cyc;
    for (int r = 0; r <= 40; r++) begin
      c = cyc;
      set_idle();
      wr = 1'b1;
      if (r == 0 || r == 4 || r == 20) begin
        a = A_KICK;   d = 32'h1;
      end else if (r == 10) begin
        a = A_KICK;   d = 32'hFFFF_FFFE;
      end else if (r == 15 || r == 28 || r == 31) begin
        a = A_STATUS; d = 32'h1;
      end else begin
        wr = 1'b0; a = '0; d = '0;
      end
      csb_valid_i = wr;
      csb_write_i = wr;
      csb_addr_i  = a;
      csb_wdat_i  = d;
      @(negedge clk_i);
      checks++;
      if ({busy_o, intr_o} !== {m_busy(c), m_pending(c)}) begin
        errors++;
        $display("FAIL intr_timing rel=%0d got busy=%b intr=%b exp busy=%b intr=%b", r, busy_o, intr_o, m_busy(c), m_pending(c));
      end
      if (intr_o === 1'b1 && rise < 0) rise = c - t0;
      if (wr) model_write(a, d, c);
      tick();
    end
    set_idle();
    checks++;
    if (rise != 4 + int'(ID) + 1) begin
      errors++;
      $display("FAIL intr_first_rise got=%0d exp=%0d", rise, 4 + int'(ID) + 1);
    end
    // Software view of the same flags through STATUS/KICK reads.
    do_write(A_KICK, 32'h1, 1'b1);
    do_read(A_KICK);
    repeat (ID) tick();
    do_read(A_STATUS);
    do_read(A_KICK);
    do_write(A_STATUS, 32'h1, 1'b0);
    do_read(A_STATUS);
  endtask

  task automatic test_out_of_range();
    do_read(16'h0100);
    do_read(BASE + 16'(NREG));
    do_write(16'hFFFF, $urandom, 1'b1);
    do_write(BASE + 16'(NREG), $urandom, 1'b0);
    for (int i = 0; i < int'(NREG); i++) do_read(BASE + 16'(i));
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [31:0] d;
    for (int n = 0; n < 40; n++) begin
      a = BASE + 16'($urandom_range(0, NREG + 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        if (a == A_KICK) d[0] = 1'b0;
        do_write(a, d, 1'($urandom_range(0, 1)));
      end else begin
        do_read(a);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [37:0] got;
    do_write(A_KICK, 32'h1, 1'b0);
    csb_valid_i = 1'b1;
    csb_write_i = 1'b0;
    csb_addr_i  = BASE + 16'd5;
    tick();
    set_idle();
    rst_i = 1'b1;
    #1;
    model_reset();
    got = {csb_ready_o, csb_rdata_valid_o, csb_rdata_o, csb_wr_complete_o, intr_o, busy_o};
    checks++;
    if (got !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midread_reset outputs got=%h exp=%h", got, {1'b1, 1'b0, 32'h0, 3'b000});
    end
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < int'(ID) + 4; k++) begin
      @(negedge clk_i);
      checks++;
      if ({csb_rdata_valid_o, intr_o, busy_o} !== 3'b000) begin
        errors++;
        $display("FAIL midread_quiet k=%0d got valid=%b intr=%b busy=%b exp=000", k, csb_rdata_valid_o, intr_o, busy_o);
      end
      tick();
    end
    do_read(BASE + 16'd5);
    do_write(BASE + 16'd5, 32'h1234_5678, 1'b1);
    do_read(BASE + 16'd5);
  endtask

  initial begin
    set_idle();
    test_reset();
    test_read_basic();
    test_write_read();
    test_back_to_back();
    test_intr();
    test_out_of_range();
    test_random();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
